// File: rtl/codificador_hamming_flujo.sv
// Purpose: streaming SECDED (extended Hamming) encoder with optional error injection.
// Latency: 1 cycle from input handshake to salida_valida/salida_palabra.
// Backpressure: 2-entry buffer; entrada_lista drops only when both entries are full.
//
// Ports:
//   reloj, reinicio_n            clock, async active-low reset
//   entrada_valida/entrada_lista input handshake for dato_entrada, modo_error, pos_error
//   modo_error                   00 none, 01 flip pos_error, 10 flip pos_error and next, 11 none
//   salida_valida/salida_lista   output handshake for salida_palabra (oldest buffered word)
//   palabras_enviadas            wrapping count of completed output handshakes
module codificador_hamming_flujo #(
    parameter  int ANCHO_DATO     = 4,
    parameter  int ANCHO_CONTADOR = 16,
    // Smallest r with 2^r >= ANCHO_DATO + r + 1, for the legal range 1..57.
    localparam int PARIDADES      = (ANCHO_DATO <= 1)  ? 2 :
                                    (ANCHO_DATO <= 4)  ? 3 :
                                    (ANCHO_DATO <= 11) ? 4 :
                                    (ANCHO_DATO <= 26) ? 5 : 6,
    localparam int ANCHO_PALABRA  = ANCHO_DATO + PARIDADES + 1,
    localparam int ANCHO_POS      = $clog2(ANCHO_PALABRA)
) (
    input  logic                      reloj,
    input  logic                      reinicio_n,
    input  logic                      entrada_valida,
    output logic                      entrada_lista,
    input  logic [ANCHO_DATO-1:0]     dato_entrada,
    input  logic [1:0]                modo_error,
    input  logic [ANCHO_POS-1:0]      pos_error,
    output logic                      salida_valida,
    input  logic                      salida_lista,
    output logic [ANCHO_PALABRA-1:0]  salida_palabra,
    output logic [ANCHO_CONTADOR-1:0] palabras_enviadas
);

    // Number of data positions (non powers of two) strictly below Hamming position p;
    // this is the dato_entrada bit that lands on position p.
    function automatic int indice_dato(int p);
        int n;
        n = 0;
        for (int q = 1; q < p; q++) begin
            if ((q & (q - 1)) != 0) n++;
        end
        return n;
    endfunction

    // Positions (bit index = p-1) whose Hamming index has bit k set.
    function automatic logic [ANCHO_PALABRA-2:0] mascara_paridad(int k);
        logic [ANCHO_PALABRA-2:0] m;
        m = '0;
        for (int i = 0; i < ANCHO_PALABRA - 1; i++) begin
            if ((((i + 1) >> k) & 1) != 0)
                m = m | ({{(ANCHO_PALABRA-2){1'b0}}, 1'b1} << i);
        end
        return m;
    endfunction

    // ------------------------------------------------------------------ encoder
    logic [ANCHO_PALABRA-2:0] datos_pos;  // data bits placed, parity slots zero
    logic [ANCHO_PALABRA-1:0] codigo;

    for (genvar p = 1; p < ANCHO_PALABRA; p++) begin : g_pos
        if ((p & (p - 1)) == 0) begin : g_par
            localparam int K = $clog2(p);
            assign datos_pos[p-1] = 1'b0;
            assign codigo[p-1]    = ^(datos_pos & mascara_paridad(K));
        end else begin : g_dat
            localparam int IDX = indice_dato(p);
            assign datos_pos[p-1] = dato_entrada[IDX];
            assign codigo[p-1]    = datos_pos[p-1];
        end
    end
    assign codigo[ANCHO_PALABRA-1] = ^codigo[ANCHO_PALABRA-2:0];

    // ---------------------------------------------------------- error injection
    // One extra bit on the position so that out-of-range values can be compared
    // against ANCHO_PALABRA even when it is a power of two.
    localparam logic [ANCHO_POS:0]       ULTIMA = (ANCHO_POS+1)'(ANCHO_PALABRA - 1);
    localparam logic [ANCHO_PALABRA-1:0] UNO    = {{(ANCHO_PALABRA-1){1'b0}}, 1'b1};

    logic [ANCHO_POS:0]       pos_ext;
    logic [ANCHO_POS:0]       pos_sig;
    logic [ANCHO_PALABRA-1:0] volteo;
    logic [ANCHO_PALABRA-1:0] palabra_nueva;

    always_comb begin
        pos_ext = {1'b0, pos_error};
        pos_sig = (pos_ext == ULTIMA) ? '0 : pos_ext + 1'b1;
        volteo  = '0;
        if (pos_ext <= ULTIMA) begin
            case (modo_error)
                2'b01:   volteo = UNO << pos_ext;
                2'b10:   volteo = (UNO << pos_ext) | (UNO << pos_sig);
                default: volteo = '0;
            endcase
        end
        palabra_nueva = codigo ^ volteo;
    end

    // ------------------------------------------------------------ buffer control
    typedef enum logic [1:0] {VACIO, MEDIO, LLENO} estado_t;

    estado_t estado, estado_sig;
    logic    hs_entrada, hs_salida;
    logic    cargar_cabeza, cargar_cola, avanzar;

    assign entrada_lista = (estado != LLENO);
    assign salida_valida = (estado != VACIO);
    assign hs_entrada    = entrada_valida & entrada_lista;
    assign hs_salida     = salida_valida & salida_lista;

    always_ff @(posedge reloj or negedge reinicio_n) begin
        if (!reinicio_n) estado <= VACIO;
        else             estado <= estado_sig;
    end

    always_comb begin
        estado_sig    = estado;
        cargar_cabeza = 1'b0;
        cargar_cola   = 1'b0;
        avanzar       = 1'b0;
        case (estado)
            VACIO: begin
                if (hs_entrada) begin
                    cargar_cabeza = 1'b1;
                    estado_sig    = MEDIO;
                end
            end
            MEDIO: begin
                case ({hs_entrada, hs_salida})
                    2'b10: begin
                        cargar_cola = 1'b1;
                        estado_sig  = LLENO;
                    end
                    2'b01: estado_sig = VACIO;
                    // Head leaves and the new word becomes the head in the same edge.
                    2'b11: cargar_cabeza = 1'b1;
                    default: ;
                endcase
            end
            LLENO: begin
                if (hs_salida) begin
                    avanzar    = 1'b1;
                    estado_sig = MEDIO;
                end
            end
            default: estado_sig = VACIO;
        endcase
    end

    // Head register drives the output directly, so the word stays stable under backpressure.
    logic [ANCHO_PALABRA-1:0] cabeza, cola;

    always_ff @(posedge reloj or negedge reinicio_n) begin
        if (!reinicio_n) begin
            cabeza <= '0;
            cola   <= '0;
        end else begin
            if (cargar_cabeza)  cabeza <= palabra_nueva;
            else if (avanzar)   cabeza <= cola;
            if (cargar_cola)    cola   <= palabra_nueva;
        end
    end

    assign salida_palabra = cabeza;

    always_ff @(posedge reloj or negedge reinicio_n) begin
        if (!reinicio_n)    palabras_enviadas <= '0;
        else if (hs_salida) palabras_enviadas <= palabras_enviadas + 1'b1;
    end

endmodule

// File: tb/tb_codificador_hamming_flujo.sv
module tb_codificador_hamming_flujo;

    logic reloj = 1'b0;
    logic reinicio_n = 1'b0;
    always #5 reloj = ~reloj;

    int vectores = 0;
    int fallos   = 0;

    // a: ANCHO_DATO=4 (8-bit word), default counter
    logic        a_ev = 0, a_el, a_sv, a_sl = 0;
    logic [3:0]  a_dat = '0;
    logic [1:0]  a_modo = '0;
    logic [2:0]  a_pos = '0;
    logic [7:0]  a_pal;
    logic [15:0] a_cnt;
    // w: ANCHO_DATO=11 (16-bit word)
    logic        w_ev = 0, w_el, w_sv, w_sl = 0;
    logic [10:0] w_dat = '0;
    logic [1:0]  w_modo = '0;
    logic [3:0]  w_pos = '0;
    logic [15:0] w_pal;
    logic [15:0] w_cnt;
    // c: ANCHO_DATO=3 (7-bit word, so a 3-bit pos_error can be out of range), 2-bit counter
    logic        c_ev = 0, c_el, c_sv, c_sl = 0;
    logic [2:0]  c_dat = '0;
    logic [1:0]  c_modo = '0;
    logic [2:0]  c_pos = '0;
    logic [6:0]  c_pal;
    logic [1:0]  c_cnt;

    codificador_hamming_flujo #(.ANCHO_DATO(4)) dut_a (
        .reloj(reloj), .reinicio_n(reinicio_n), .entrada_valida(a_ev), .entrada_lista(a_el),
        .dato_entrada(a_dat), .modo_error(a_modo), .pos_error(a_pos), .salida_valida(a_sv),
        .salida_lista(a_sl), .salida_palabra(a_pal), .palabras_enviadas(a_cnt));

    codificador_hamming_flujo #(.ANCHO_DATO(11)) dut_w (
        .reloj(reloj), .reinicio_n(reinicio_n), .entrada_valida(w_ev), .entrada_lista(w_el),
        .dato_entrada(w_dat), .modo_error(w_modo), .pos_error(w_pos), .salida_valida(w_sv),
        .salida_lista(w_sl), .salida_palabra(w_pal), .palabras_enviadas(w_cnt));

    codificador_hamming_flujo #(.ANCHO_DATO(3), .ANCHO_CONTADOR(2)) dut_c (
        .reloj(reloj), .reinicio_n(reinicio_n), .entrada_valida(c_ev), .entrada_lista(c_el),
        .dato_entrada(c_dat), .modo_error(c_modo), .pos_error(c_pos), .salida_valida(c_sv),
        .salida_lista(c_sl), .salida_palabra(c_pal), .palabras_enviadas(c_cnt));

    task automatic tic();
        @(posedge reloj);
        #1;
    endtask

    task automatic aplicar_reset();
        reinicio_n = 1'b0;
        a_ev = 0; w_ev = 0; c_ev = 0;
        a_modo = '0; a_pos = '0; c_modo = '0; c_pos = '0;
        repeat (2) tic();
        reinicio_n = 1'b1;
    endtask

    task automatic test_reset();
        reinicio_n = 1'b0;
        repeat (2) tic();
        vectores++; if (a_sv !== 1'b0) begin fallos++; $display("FAIL reset_salida_valida: got %b expected 0", a_sv); end
        vectores++; if (a_el !== 1'b1) begin fallos++; $display("FAIL reset_entrada_lista: got %b expected 1", a_el); end
        vectores++; if (a_pal !== 8'h00) begin fallos++; $display("FAIL reset_palabra: got %h expected 00", a_pal); end
        vectores++; if (a_cnt !== 16'd0) begin fallos++; $display("FAIL reset_contador: got %0d expected 0", a_cnt); end
        reinicio_n = 1'b1;
        tic();
        vectores++; if (a_el !== 1'b1) begin fallos++; $display("FAIL reset_lista_tras_soltar: got %b expected 1", a_el); end
    endtask

    task automatic test_basic_encode();
        aplicar_reset();
        a_sl = 1; a_ev = 1; a_dat = 4'hB;
        tic();
        a_ev = 0;
        vectores++; if (a_sv !== 1'b1) begin fallos++; $display("FAIL basico_valida: got %b expected 1", a_sv); end
        vectores++; if (a_pal !== 8'h55) begin fallos++; $display("FAIL basico_palabra: got %h expected 55", a_pal); end
        tic();
        vectores++; if (a_cnt !== 16'd1) begin fallos++; $display("FAIL basico_contador: got %0d expected 1", a_cnt); end
        vectores++; if (a_sv !== 1'b0) begin fallos++; $display("FAIL basico_vacio: got %b expected 0", a_sv); end
    endtask

    task automatic test_back_to_back();
        aplicar_reset();
        a_sl = 1; a_ev = 1; a_dat = 4'h0;
        tic();
        vectores++; if (a_pal !== 8'h00 || a_sv !== 1'b1) begin fallos++; $display("FAIL esquina_0: got %h/%b expected 00/1", a_pal, a_sv); end
        a_dat = 4'hF;
        tic();
        a_ev = 0;
        vectores++; if (a_pal !== 8'hFF || a_sv !== 1'b1) begin fallos++; $display("FAIL esquina_F: got %h/%b expected ff/1", a_pal, a_sv); end
        tic();
        vectores++; if (a_cnt !== 16'd2) begin fallos++; $display("FAIL esquina_contador: got %0d expected 2", a_cnt); end
    endtask

    task automatic test_error_injection();
        logic [1:0] am [0:4] = '{2'b01, 2'b10, 2'b11, 2'b01, 2'b00};
        logic [2:0] ap [0:4] = '{3'd3, 3'd7, 3'd3, 3'd0, 3'd5};
        logic [7:0] ae [0:4] = '{8'h5D, 8'hD4, 8'h55, 8'h54, 8'h55};
        // 7-bit word for data 0x5 encodes to 0x2D; pos 7 is beyond the word.
        logic [1:0] cm [0:4] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b00};
        logic [2:0] cp [0:4] = '{3'd7, 3'd7, 3'd6, 3'd6, 3'd7};
        logic [6:0] ce [0:4] = '{7'h2D, 7'h2D, 7'h6D, 7'h6C, 7'h2D};
        aplicar_reset();
        a_sl = 1; a_dat = 4'hB; c_sl = 1; c_dat = 3'h5;
        for (int i = 0; i < 5; i++) begin
            a_ev = 1; a_modo = am[i]; a_pos = ap[i];
            c_ev = 1; c_modo = cm[i]; c_pos = cp[i];
            tic();
            vectores++; if (a_pal !== ae[i] || a_sv !== 1'b1) begin fallos++; $display("FAIL inyeccion_%0d: got %h expected %h", i, a_pal, ae[i]); end
            vectores++; if (c_pal !== ce[i] || c_sv !== 1'b1) begin fallos++; $display("FAIL inyeccion7_%0d: got %h expected %h", i, c_pal, ce[i]); end
        end
        a_ev = 0; c_ev = 0; a_modo = '0; a_pos = '0; c_modo = '0; c_pos = '0;
        tic();
    endtask

    task automatic test_backpressure();
        aplicar_reset();
        a_sl = 0; a_ev = 1; a_dat = 4'h1;
        tic();
        vectores++; if (a_el !== 1'b1 || a_pal !== 8'h87) begin fallos++; $display("FAIL contra_1: got %b/%h expected 1/87", a_el, a_pal); end
        a_dat = 4'h2;
        tic();
        vectores++; if (a_el !== 1'b0 || a_pal !== 8'h87) begin fallos++; $display("FAIL contra_lleno: got %b/%h expected 0/87", a_el, a_pal); end
        a_dat = 4'h3;
        tic();
        vectores++; if (a_el !== 1'b0 || a_pal !== 8'h87 || a_sv !== 1'b1) begin fallos++; $display("FAIL contra_retiene: got %b/%h expected 0/87", a_el, a_pal); end
        a_sl = 1;
        tic();
        vectores++; if (a_el !== 1'b1 || a_pal !== 8'h99) begin fallos++; $display("FAIL contra_2: got %b/%h expected 1/99", a_el, a_pal); end
        tic();
        a_ev = 0;
        vectores++; if (a_pal !== 8'h1E || a_sv !== 1'b1) begin fallos++; $display("FAIL contra_3: got %h/%b expected 1e/1", a_pal, a_sv); end
        tic();
        vectores++; if (a_sv !== 1'b0 || a_cnt !== 16'd3) begin fallos++; $display("FAIL contra_fin: got %b/%0d expected 0/3", a_sv, a_cnt); end
    endtask

    task automatic test_wide();
        aplicar_reset();
        w_sl = 1; w_ev = 1; w_dat = 11'h7FF;
        tic();
        vectores++; if (w_pal !== 16'hFFFF) begin fallos++; $display("FAIL ancho_7ff: got %h expected ffff", w_pal); end
        w_dat = 11'h001;
        tic();
        w_ev = 0;
        vectores++; if (w_pal !== 16'h8007) begin fallos++; $display("FAIL ancho_001: got %h expected 8007", w_pal); end
        tic();
    endtask

    task automatic test_reset_mid();
        aplicar_reset();
        a_sl = 0; a_ev = 1; a_dat = 4'hB;
        repeat (2) tic();
        vectores++; if (a_el !== 1'b0) begin fallos++; $display("FAIL rmedio_lleno: got %b expected 0", a_el); end
        a_ev = 0; a_sl = 1;
        reinicio_n = 1'b0;
        #1;
        vectores++; if (a_sv !== 1'b0 || a_el !== 1'b1 || a_pal !== 8'h00) begin fallos++; $display("FAIL rmedio_inmediato: got %b/%b/%h expected 0/1/00", a_sv, a_el, a_pal); end
        tic();
        vectores++; if (a_cnt !== 16'd0 || a_sv !== 1'b0) begin fallos++; $display("FAIL rmedio_sin_envio: got %0d/%b expected 0/0", a_cnt, a_sv); end
        reinicio_n = 1'b1;
        a_ev = 1; a_dat = 4'hB;
        tic();
        a_ev = 0;
        vectores++; if (a_pal !== 8'h55 || a_sv !== 1'b1) begin fallos++; $display("FAIL rmedio_despues: got %h/%b expected 55/1", a_pal, a_sv); end
        tic();
    endtask

    task automatic test_counter_wrap();
        aplicar_reset();
        c_sl = 1; c_ev = 1; c_dat = 3'h5;
        repeat (5) tic();
        c_ev = 0;
        vectores++; if (c_cnt !== 2'd0) begin fallos++; $display("FAIL contador_4: got %0d expected 0", c_cnt); end
        tic();
        vectores++; if (c_cnt !== 2'd1) begin fallos++; $display("FAIL contador_5: got %0d expected 1", c_cnt); end
    endtask

    initial begin
        test_reset();
        test_basic_encode();
        test_back_to_back();
        test_error_injection();
        test_backpressure();
        test_wide();
        test_reset_mid();
        test_counter_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectores, fallos);
        $finish;
    end

endmodule
